epsilon_greedy_select: RTL and testbench

//   Consumer end of the 16-bit LFSR randomizer interface. At reset it seeds the

---
 rtl/epsilon_greedy_select.sv | 165 ++++++++++++++++
 tb/tb_epsilon_greedy_select.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/epsilon_greedy_select.sv
// Epsilon-greedy action selector; consumer end of a 16-bit LFSR randomizer.
//
// After reset it seeds the randomizer (lfsr_start/lfsr_ic) for SEED_CYCLES edges.
// Each accepted request then makes one epsilon-greedy choice among 4 actions.
// Results appear with a fixed latency of 3 cycles on both the explore and greedy paths.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   seed            LFSR seed; lfsr_ic substitutes SEED_DEFAULT for an all-zero seed
//   lfsr_start      high while seeding; randomizer loads lfsr_ic
//   lfsr_ic         randomizer initial condition (combinational)
//   rand_in         randomizer q[7:0]
//   req             request level, sampled in IDLE
//   epsilon         explore threshold, latched on accept
//   q0..q3          signed Q-values, latched on accept
//   busy            high whenever not IDLE
//   valid           one-cycle result strobe
//   action          chosen action (held between results)
//   explored        1 = random choice, 0 = greedy (held with action)
module epsilon_greedy_select #(
  parameter int unsigned Q_W          = 16,
  parameter int unsigned SEED_CYCLES  = 2,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           seed,
  output logic                  lfsr_start,
  output logic [15:0]           lfsr_ic,
  input  logic [7:0]            rand_in,
  input  logic                  req,
  input  logic [7:0]            epsilon,
  input  logic signed [Q_W-1:0] q0,
  input  logic signed [Q_W-1:0] q1,
  input  logic signed [Q_W-1:0] q2,
  input  logic signed [Q_W-1:0] q3,
  output logic                  busy,
  output logic                  valid,
  output logic [1:0]            action,
  output logic                  explored
);

  localparam int unsigned CntW = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SEED_CYCLES - 1);

  typedef enum logic [2:0] {
    StSeed    = 3'd0,
    StIdle    = 3'd1,
    StDraw    = 3'd2,
    StExplore = 3'd3,
    StCmp     = 3'd4,
    StDone    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            eps_q, eps_d;
  logic signed [Q_W-1:0] q_q [4];
  logic signed [Q_W-1:0] q_d [4];
  logic [1:0]            action_q, action_d;
  logic                  explored_q, explored_d;

  logic [1:0]            best_idx;
  logic signed [Q_W-1:0] best_val;

  // An all-zero seed would lock the LFSR, so substitute the default.
  assign lfsr_ic = (seed == 16'h0000) ? SEED_DEFAULT : seed;

  // Status outputs decode the state register directly so an asynchronous
  // reset takes effect without waiting for a clock edge.
  assign lfsr_start = (state_q == StSeed);
  assign busy       = (state_q != StIdle);
  assign valid      = (state_q == StDone);
  assign action     = action_q;
  assign explored   = explored_q;

  // Argmax over latched Q-values; strict '>' keeps the lowest index on ties.
  always_comb begin
    best_idx = 2'd0;
    best_val = q_q[0];
    for (int i = 1; i < 4; i++) begin
      if (q_q[i] > best_val) begin
        best_idx = 2'(i);
        best_val = q_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    eps_d      = eps_q;
    q_d        = q_q;
    action_d   = action_q;
    explored_d = explored_q;

    unique case (state_q)
      StSeed: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (req) begin
          eps_d   = epsilon;
          q_d[0]  = q0;
          q_d[1]  = q1;
          q_d[2]  = q2;
          q_d[3]  = q3;
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (rand_in < eps_q) begin
          explored_d = 1'b1;
          state_d    = StExplore;
        end else begin
          explored_d = 1'b0;
          state_d    = StCmp;
        end
      end
      StExplore: begin
        // Fresh byte from the randomizer, not the one used for the draw.
        action_d = rand_in[7:6];
        state_d  = StDone;
      end
      StCmp: begin
        action_d = best_idx;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StSeed;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StSeed;
      cnt_q      <= '0;
      eps_q      <= '0;
      q_q[0]     <= '0;
      q_q[1]     <= '0;
      q_q[2]     <= '0;
      q_q[3]     <= '0;
      action_q   <= '0;
      explored_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      eps_q      <= eps_d;
      q_q        <= q_d;
      action_q   <= action_d;
      explored_q <= explored_d;
    end
  end

endmodule

// File: tb/tb_epsilon_greedy_select.sv
module tb_epsilon_greedy_select;

  logic               clk;
  logic               rst_n;
  logic [15:0]        seed;
  logic               lfsr_start;
  logic [15:0]        lfsr_ic;
  logic [7:0]         rand_in;
  logic               req;
  logic [7:0]         epsilon;
  logic signed [15:0] q0, q1, q2, q3;
  logic               busy;
  logic               valid;
  logic [1:0]         action;
  logic               explored;

  int checks = 0;
  int errors = 0;

  // Reference randomizer; the bench may override its byte with a stub value.
  logic [15:0] lfsr_m;
  logic        use_stub;
  logic [7:0]  stub;

  always_ff @(posedge clk) begin
    if (lfsr_start) lfsr_m <= lfsr_ic;
    else            lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  assign rand_in = use_stub ? stub : lfsr_m[7:0];

  epsilon_greedy_select dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed      (seed),
    .lfsr_start(lfsr_start),
    .lfsr_ic   (lfsr_ic),
    .rand_in   (rand_in),
    .req       (req),
    .epsilon   (epsilon),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .busy      (busy),
    .valid     (valid),
    .action    (action),
    .explored  (explored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request starting from IDLE. Inputs are scrambled right after the
  // accept edge to confirm they were latched. Optionally pulses req in DRAW/CMP.
  task automatic run_req(input string tag, input logic [7:0] e,
                         input logic signed [15:0] a, input logic signed [15:0] b,
                         input logic signed [15:0] c, input logic signed [15:0] d,
                         input logic [7:0] r_draw, input logic [7:0] r_exp,
                         input logic [1:0] x_act, input logic x_exp, input logic pulse);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    epsilon = e; q0 = a; q1 = b; q2 = c; q3 = d;
    stub = r_draw; req = 1'b1;
    step();                                   // accept edge t
    req = pulse;
    epsilon = ~e; q0 = -16'sd32768; q1 = -16'sd32768; q2 = -16'sd32768; q3 = 16'sh7fff;
    check({tag, " t+1 busy"}, 32'(busy), 32'd1);
    check({tag, " t+1 valid"}, 32'(valid), 32'd0);
    step();                                   // DRAW edge
    stub = r_exp;
    check({tag, " t+2 explored"}, 32'(explored), 32'(x_exp));
    check({tag, " t+2 valid"}, 32'(valid), 32'd0);
    step();                                   // EXPLORE/CMP edge
    req = 1'b0;
    check({tag, " t+3 valid"}, 32'(valid), 32'd1);
    check({tag, " t+3 action"}, 32'(action), 32'(x_act));
    check({tag, " t+3 explored"}, 32'(explored), 32'(x_exp));
    step();
    check({tag, " after valid"}, 32'(valid), 32'd0);
    check({tag, " after busy"}, 32'(busy), 32'd0);
    check({tag, " action hold"}, 32'(action), 32'(x_act));
    step();
    check({tag, " no extra valid"}, 32'(valid), 32'd0);
    check({tag, " still idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; seed = 16'h1234; req = 1'b0; epsilon = '0;
    q0 = '0; q1 = '0; q2 = '0; q3 = '0; use_stub = 1'b0; stub = '0;
    #1;
    // Reset state
    check("rst lfsr_start", 32'(lfsr_start), 32'd1);
    check("rst busy", 32'(busy), 32'd1);
    check("rst valid", 32'(valid), 32'd0);
    check("rst action", 32'(action), 32'd0);
    check("rst explored", 32'(explored), 32'd0);
    check("rst lfsr_ic", 32'(lfsr_ic), 32'h1234);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("seed e1 start", 32'(lfsr_start), 32'd1);
    check("seed e1 busy", 32'(busy), 32'd1);
    step();
    check("seed e2 start", 32'(lfsr_start), 32'd0);
    check("seed e2 busy", 32'(busy), 32'd0);
    check("seed loaded", 32'(lfsr_m), 32'h1234);

    // Zero seed substitutes the default
    rst_n = 1'b0; seed = 16'h0000;
    #1;
    check("zero seed ic", 32'(lfsr_ic), 32'hACE1);
    step();
    rst_n = 1'b1;
    step(); step();
    check("zero seed start", 32'(lfsr_start), 32'd0);
    check("zero seed loaded", 32'(lfsr_m), 32'hACE1);
    repeat (8) step();
    check("lfsr nonzero", 32'(lfsr_m != 16'h0000), 32'd1);

    use_stub = 1'b1;
    // Greedy, tie 2/3 resolves to 2, eps=0 never explores
    run_req("greedy tie", 8'd0, 16'sd10, -16'sd5, 16'sd30, 16'sd30, 8'h00, 8'hFF, 2'd2, 1'b0, 1'b0);
    // Explore with eps=255; action from EXPLORE byte C3
    run_req("explore", 8'hFF, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 8'h10, 8'hC3, 2'd3, 1'b1, 1'b0);
    // r == eps is not an explore; signed argmax with ignored req pulses
    run_req("greedy neg", 8'h80, -16'sd1, -16'sd1, -16'sd1, -16'sd2, 8'h80, 8'h00, 2'd0, 1'b0, 1'b1);
    // eps=255 with r=255 stays greedy
    run_req("eps255 r255", 8'hFF, -16'sd100, 16'sd7, -16'sd3, 16'sd6, 8'hFF, 8'hC0, 2'd1, 1'b0, 1'b0);
    // r just below eps explores, action from second byte
    run_req("explore low", 8'h81, 16'sd50, 16'sd0, 16'sd0, 16'sd0, 8'h80, 8'h40, 2'd1, 1'b1, 1'b0);

    // Reset in the middle of EXPLORE
    epsilon = 8'hFF; stub = 8'h10; req = 1'b1;
    step();
    req = 1'b0; stub = 8'hC3;
    step();
    check("mid explored", 32'(explored), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async valid", 32'(valid), 32'd0);
    check("async busy", 32'(busy), 32'd1);
    check("async start", 32'(lfsr_start), 32'd1);
    check("async explored", 32'(explored), 32'd0);
    check("async action", 32'(action), 32'd0);
    step();
    check("held rst valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    step();
    check("reseed e1 start", 32'(lfsr_start), 32'd1);
    step();
    check("reseed e2 start", 32'(lfsr_start), 32'd0);
    run_req("post reset", 8'd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 8'h00, 8'h00, 2'd3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
